// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    localparam int unsigned DEFAULT_DEPTH_WORDS = 2048;
    localparam int unsigned HDR_W               = 16;
    localparam int unsigned CHK_W               = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_LO = 3'd1,
        ST_HDR_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // States in which a load session is active and bytes are accepted.
    function automatic logic in_session(state_e s);
        return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// Packs a byte stream little-endian into 32-bit words and flags the 4th byte.
module loader_word_packer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] sr_q, sr_d;

    // The first byte of a word ends up in the lowest lane after all shifts.
    assign word_o      = {byte_i, sr_q};
    assign word_done_o = byte_en_i && !clr_i && (cnt_q == 2'd3);

    // Next byte count and shift-register contents.
    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr_i) begin
            cnt_d = 2'd0;
            sr_d  = 24'd0;
        end else if (byte_en_i) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {byte_i, sr_q[23:8]};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            sr_q  <= 24'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: header, little-endian words, XOR checksum.
// Byte handshake: a byte moves on any rising edge where byte_valid_i and
// byte_ready_o are both 1; the source holds byte_data_i until then.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        byte_ready_o,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        cpu_rst_no,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output state_e      dbg_state_o
);

    state_e             state_q, state_d;
    logic [7:0]         n_lo_q, n_lo_d;
    logic [HDR_W-1:0]   n_q, n_d;
    logic [HDR_W-1:0]   idx_q, idx_d;
    logic [CHK_W-1:0]   acc_q, acc_d;
    logic               we_q, we_d;
    logic [31:0]        waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               cpu_rst_n_q, cpu_rst_n_d;

    logic               xfer;
    logic [HDR_W-1:0]   hdr_n;
    logic               pk_clr;
    logic               pk_en;
    logic [31:0]        pk_word;
    logic               pk_done;

    assign xfer  = byte_valid_i && ready_q;
    assign hdr_n = {byte_data_i, n_lo_q};
    assign pk_en = xfer && (state_q == ST_DATA);

    loader_word_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (pk_clr),
        .byte_en_i   (pk_en),
        .byte_i      (byte_data_i),
        .word_o      (pk_word),
        .word_done_o (pk_done)
    );

    // Next-state, counters, write port and status outputs (all registered).
    always_comb begin
        state_d = state_q;
        n_lo_d  = n_lo_q;
        n_d     = n_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        pk_clr  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_HDR_LO;
                    idx_d   = '0;
                    acc_d   = '0;
                    pk_clr  = 1'b1;
                end
            end
            ST_HDR_LO: begin
                if (xfer) begin
                    n_lo_d  = byte_data_i;
                    state_d = ST_HDR_HI;
                end
            end
            ST_HDR_HI: begin
                if (xfer) begin
                    n_d = hdr_n;
                    if ((hdr_n != '0) && ({16'd0, hdr_n} <= DEPTH_WORDS)) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    acc_d = acc_q ^ byte_data_i;
                end
                if (pk_done) begin
                    we_d    = 1'b1;
                    waddr_d = BASE_ADDR + {14'd0, idx_q, 2'b00};
                    wdata_d = pk_word;
                    // The index stops at N-1: the last word hands over to CHK.
                    if (idx_q == n_q - 16'd1) begin
                        state_d = ST_CHK;
                    end else begin
                        idx_d = idx_q + 16'd1;
                    end
                end
            end
            ST_CHK: begin
                if (xfer) begin
                    state_d = (byte_data_i == acc_q) ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d     = in_session(state_d);
        busy_d      = in_session(state_d);
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
        cpu_rst_n_d = (state_d == ST_DONE);
    end

    // Registers; reset wins over any transfer on the same edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            n_lo_q      <= '0;
            n_q         <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            n_lo_q      <= n_lo_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign byte_ready_o = ready_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign cpu_rst_no   = cpu_rst_n_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_i = 1'b0;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = 8'd0;
    logic        byte_ready_o;
    logic        we_o;
    logic [31:0] waddr_o;
    logic [31:0] wdata_o;
    logic        cpu_rst_no;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    state_e      dbg_state;

    int n_vec  = 0;
    int n_miss = 0;
    int we_count = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words [0:2047];

    imem_loader dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .we_o         (we_o),
        .waddr_o      (waddr_o),
        .wdata_o      (wdata_o),
        .cpu_rst_no   (cpu_rst_no),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state)
    );

    // Clock
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk_i) begin
        if (we_o === 1'b1) begin
            logic [63:0] e;
            we_count++;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_miss++;
                $error("FAIL unexpected_write observed addr=%h data=%h expected no write", waddr_o, wdata_o);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("waddr", waddr_o, e[63:32]);
                chk("wdata", wdata_o, e[31:0]);
            end
        end
    end

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Drives one byte and returns on the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        if (stall) begin
            int k = 0;
            while ($urandom_range(0, 1) == 1 && k < 16) begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'($urandom);
                @(negedge clk_i);
                k++;
            end
        end
        byte_valid_i = 1'b1;
        byte_data_i  = b;
        guard = 0;
        while (byte_ready_o !== 1'b1 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 50) begin
            n_vec++;
            n_miss++;
            $error("FAIL ready_timeout observed byte_ready_o=%b expected 1", byte_ready_o);
        end
        @(negedge clk_i);
        byte_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] addr, input bit stall);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) exp_q.push_back({addr, w});
            send_byte(w[8*k +: 8], stall);
        end
    endtask

    // Header, words[0..n-1], then checksum (model XOR unless forced).
    task automatic run_load(input int n, input bit force_chk, input logic [7:0] chk_val,
                            input bit stall, input int mid_start);
        logic [7:0]  acc;
        logic [15:0] n16;
        n16 = 16'(n);
        acc = 8'd0;
        send_byte(n16[7:0], stall);
        send_byte(n16[15:8], stall);
        for (int i = 0; i < n; i++) begin
            if (i == mid_start) begin
                pulse_start();
                chk("mid_start_busy", {31'd0, busy_o}, 32'd1);
            end
            acc = acc ^ words[i][7:0] ^ words[i][15:8] ^ words[i][23:16] ^ words[i][31:24];
            send_word(words[i], 32'(i) * 32'd4, stall);
        end
        send_byte(force_chk ? chk_val : acc, stall);
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic err, input logic cpu_n);
        chk({tag, "_busy"},   {31'd0, busy_o},     {31'd0, busy});
        chk({tag, "_done"},   {31'd0, done_o},     {31'd0, done});
        chk({tag, "_err"},    {31'd0, err_o},      {31'd0, err});
        chk({tag, "_cpu_rn"}, {31'd0, cpu_rst_no}, {31'd0, cpu_n});
    endtask

    initial begin
        int base_we;
        logic [31:0] w_single;

        @(negedge clk_i);
        do_reset();

        // Reset state
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_ready", {31'd0, byte_ready_o}, 32'd0);
        chk("reset_we",    {31'd0, we_o},         32'd0);
        chk("reset_waddr", waddr_o, 32'd0);
        chk("reset_wdata", wdata_o, 32'd0);

        // Two-word load; the XOR of these eight bytes is 0x94.
        words[0] = 32'h00D0_0713;
        words[1] = 32'h0387_C713;
        pulse_start();
        check_status("start", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("start_ready", {31'd0, byte_ready_o}, 32'd1);
        base_we = we_count;
        run_load(2, 1'b0, 8'h00, 1'b0, -1);
        check_status("good2", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("good2_ready", {31'd0, byte_ready_o}, 32'd0);
        chk("good2_writes", 32'(we_count - base_we), 32'd2);
        chk("good2_hold_addr", waddr_o, 32'h0000_0004);
        chk("good2_hold_data", wdata_o, 32'h0387_C713);

        // Same stream with checksum 0x00
        pulse_start();
        check_status("restart", 1'b1, 1'b0, 1'b0, 1'b0);
        base_we = we_count;
        run_load(2, 1'b1, 8'h00, 1'b0, -1);
        check_status("badchk", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("badchk_writes", 32'(we_count - base_we), 32'd2);

        // Header N=0 and N=2049 are rejected without any write
        pulse_start();
        base_we = we_count;
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check_status("n0", 1'b0, 1'b0, 1'b1, 1'b0);
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h08, 1'b0);
        check_status("n2049", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk_i);
        chk("hdr_err_writes", 32'(we_count - base_we), 32'd0);

        // N=1 without and with random byte_valid stalls
        w_single = $urandom;
        words[0] = w_single;
        pulse_start();
        base_we = we_count;
        run_load(1, 1'b0, 8'h00, 1'b0, -1);
        check_status("n1", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("n1_writes", 32'(we_count - base_we), 32'd1);
        pulse_start();
        base_we = we_count;
        run_load(1, 1'b0, 8'h00, 1'b1, -1);
        check_status("n1_stall", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("n1_stall_writes", 32'(we_count - base_we), 32'd1);
        chk("n1_stall_data", wdata_o, w_single);

        // Reset after 5 data bytes, then a fresh N=1 load
        words[0] = 32'h1122_3344;
        pulse_start();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_word(words[0], 32'd0, 1'b0);
        send_byte(8'hAA, 1'b0);
        base_we = we_count;
        do_reset();
        check_status("midrst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_waddr", waddr_o, 32'd0);
        chk("midrst_wdata", wdata_o, 32'd0);
        words[0] = 32'hCAFE_F00D;
        pulse_start();
        run_load(1, 1'b0, 8'h00, 1'b0, -1);
        check_status("after_rst", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("after_rst_writes", 32'(we_count - base_we), 32'd1);
        chk("after_rst_addr", waddr_o, 32'd0);

        // Reset on the same edge as a word's 4th byte: no write may follow
        pulse_start();
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        base_we = we_count;
        byte_valid_i = 1'b1;
        byte_data_i  = 8'h04;
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        byte_valid_i = 1'b0;
        @(negedge clk_i);
        chk("rst_edge_writes", 32'(we_count - base_we), 32'd0);
        chk("rst_edge_busy", {31'd0, busy_o}, 32'd0);

        // Full-depth load with a start pulse in the middle
        for (int i = 0; i < 2048; i++) words[i] = $urandom;
        pulse_start();
        base_we = we_count;
        run_load(2048, 1'b0, 8'h00, 1'b0, 1000);
        check_status("full", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("full_writes", 32'(we_count - base_we), 32'd2048);
        chk("full_last_addr", waddr_o, 32'h0000_1FFC);
        chk("full_last_data", wdata_o, words[2047]);

        repeat (3) @(negedge clk_i);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
